// File: rtl/fixed_ln_seq.sv
// fixed_ln_seq: multi-cycle natural logarithm of a Q16.16 sign-magnitude operand.
// The result is log2 split into an integer part (from the MSB position) and
// 16 fractional bits (from repeated squaring), then scaled by ln(2).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand; in_ready high
// NORM  | locate the MSB, normalise the mantissa to Q1.30, set integer log2
// ITER  | one squaring step per cycle, one fractional log2 bit per step
// SCALE | form the signed log2 value and multiply by ln(2)
// DONE  | result presented; held until the consumer takes it
module fixed_ln_seq #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int ITERS = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    // ln(2) in Q0.16
    localparam logic [15:0] LN2_Q16 = 16'hB172;

    state_t              r_state;
    state_t              w_state_next;
    logic [N-2:0]        r_mag;
    logic [N-2:0]        r_y;
    logic signed [5:0]   r_ipart;
    logic [Q-1:0]        r_frac;
    logic [3:0]          r_cnt;
    logic [N-1:0]        r_out_data;
    logic                r_out_err;

    logic                w_in_err;
    logic [4:0]          w_msb;
    logic [N-2:0]        w_norm;
    logic signed [5:0]   w_ipart;
    logic [61:0]         w_prod;
    logic [N-2:0]        w_y_next;
    logic [21:0]         w_l;
    logic                w_l_neg;
    logic [21:0]         w_l_abs;
    logic [37:0]         w_scaled;
    logic [21:0]         w_mag;
    logic [N-1:0]        w_scale_out;
    logic                w_unused;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

    // Zero magnitude (including negative zero) and any negative value are out of domain.
    assign w_in_err = (in_data[N-2:0] == '0) || in_data[N-1];

    // Priority encoder: position of the highest set magnitude bit.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < N-1; i++) begin
            if (r_mag[i]) begin
                w_msb = 5'(i);
            end
        end
    end

    assign w_norm  = r_mag << (5'd30 - w_msb);
    assign w_ipart = 6'({1'b0, w_msb}) - 6'sd16;

    // Squaring step: a carry into bit 61 means y*y >= 2, so halve and emit a 1.
    assign w_prod   = 62'(r_y) * 62'(r_y);
    assign w_y_next = w_prod[61] ? w_prod[61:31] : w_prod[60:30];

    // Signed log2 in Q6.16, then |log2| * ln(2) truncated back to Q.16.
    assign w_l      = {r_ipart, 16'h0000} + {6'b0, r_frac};
    assign w_l_neg  = w_l[21];
    assign w_l_abs  = w_l_neg ? (22'd0 - w_l) : w_l;
    assign w_scaled = 38'(w_l_abs) * 38'(LN2_Q16);
    assign w_mag    = w_scaled[37:16];
    // A result that truncates to zero is reported as +0, never -0.
    assign w_scale_out = {w_l_neg && (w_mag != '0), 9'b0, w_mag};

    assign w_unused = ^{w_prod[29:0], w_scaled[15:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = w_in_err ? S_DONE : S_NORM;
            S_NORM:  w_state_next = S_ITER;
            S_ITER:  if (r_cnt == 4'(ITERS-1)) w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers; the output register is only written at accept (error) and in SCALE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mag      <= '0;
            r_y        <= '0;
            r_ipart    <= '0;
            r_frac     <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_in_err) begin
                            r_out_data <= '1;
                            r_out_err  <= 1'b1;
                        end else begin
                            r_mag <= in_data[N-2:0];
                        end
                    end
                end
                S_NORM: begin
                    r_y     <= w_norm;
                    r_ipart <= w_ipart;
                    r_frac  <= '0;
                    r_cnt   <= '0;
                end
                S_ITER: begin
                    r_y    <= w_y_next;
                    r_frac <= {r_frac[Q-2:0], w_prod[61]};
                    r_cnt  <= r_cnt + 4'd1;
                end
                S_SCALE: begin
                    r_out_data <= w_scale_out;
                    r_out_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_ln_seq.sv
// tb_fixed_ln_seq: directed vectors with hand-computed ln results for fixed_ln_seq.
module tb_fixed_ln_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int n_chk  = 0;
    int n_pass = 0;

    fixed_ln_seq #(.N(32), .Q(16), .ITERS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, want);
    endtask

    // Present one operand, return edges counted after the accept edge until out_valid.
    task automatic do_op(input logic [31:0] x, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transaction with out_ready high; tol > 0 accepts |out - want| <= tol.
    task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] want,
                           input logic want_err, input int want_lat, input int tol);
        int          lat;
        logic [31:0] diff;
        do_op(x, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
        if (tol == 0) begin
            chk({tag, "_data"}, out_data, want);
        end else begin
            diff = (out_data > want) ? out_data - want : want - out_data;
            chk({tag, "_within_tol"}, {31'b0, diff <= 32'(tol)}, 32'd1);
        end
        chk({tag, "_err"}, {31'b0, out_err}, {31'b0, want_err});
        @(posedge clk); #1;
        chk({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'h0);
        chk("rst_out_err",   {31'b0, out_err}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;

        run_vec("one",  32'h0001_0000, 32'h0000_0000, 1'b0, 18, 0);
        run_vec("two",  32'h0002_0000, 32'h0000_B172, 1'b0, 18, 0);
        run_vec("half", 32'h0000_8000, 32'h8000_B172, 1'b0, 18, 0);
        run_vec("tiny", 32'h0000_0001, 32'h800B_1720, 1'b0, 18, 0);
        run_vec("max",  32'h7FFF_FFFF, 32'h000A_65AE, 1'b0, 18, 3);
        run_vec("e",    32'h0002_B7E1, 32'h0001_0000, 1'b0, 18, 3);
        // Error results appear on the accept edge itself: no extra edges.
        run_vec("zero", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_vec("negz", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_vec("neg1", 32'h8001_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);

        // Backpressure: result held while out_ready low, new operand ignored.
        out_ready = 1'b0;
        do_op(32'h0000_8000, lat);
        chk("bp_lat", 32'(lat), 32'd18);
        in_data  = 32'h7FFF_FFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_out_data",  out_data, 32'h8000_B172);
            chk("bp_in_ready",  {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  {31'b0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_data_kept", out_data, 32'h8000_B172);
        run_vec("b2b", 32'h0002_0000, 32'h0000_B172, 1'b0, 18, 0);

        // Reset during ITER aborts the operation.
        in_data  = 32'h0001_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data",  out_data, 32'h0);
        chk("mid_rst_in_ready",  {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_output", {31'b0, out_valid}, 32'd0);
        run_vec("post_rst", 32'h0001_0000, 32'h0000_0000, 1'b0, 18, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
